// File: rtl/defuse_ctl.sv
// Right-click flag sequencer and new-game flag clear for the Saper defuse-field storage.
// Commands are issued two cycles after the click is accepted. A click that arrives while the block is busy is dropped.
module defuse_ctl #(
  parameter int MINES_EASY   = 10,
  parameter int MINES_MEDIUM = 15,
  parameter int MINES_HARD   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       new_game,
  input  logic       click_req,
  input  logic [4:0] click_x,
  input  logic [4:0] click_y,
  input  logic       flag_rd,
  input  logic       revealed_rd,
  output logic [4:0] addr_x,
  output logic [4:0] addr_y,
  output logic       defuse,
  output logic       undefuse,
  output logic [4:0] ind_x,
  output logic [4:0] ind_y,
  output logic [4:0] arr_x_refresh,
  output logic [4:0] arr_y_refresh,
  output logic [5:0] flags_left,
  output logic       flag_limit,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  function automatic logic [1:0] lvl_norm(input logic [1:0] l);
    return (l == 2'd0) ? 2'd1 : l;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] level_q;
  logic [4:0] cx_q, cx_d, cy_q, cy_d;
  logic [4:0] lx_q, lx_d, ly_q, ly_d;
  logic [4:0] ind_x_q, ind_x_d, ind_y_q, ind_y_d;
  logic [4:0] rx_q, rx_d, ry_q, ry_d;
  logic [5:0] flags_q, flags_d;
  logic       defuse_q, defuse_d, undefuse_q, undefuse_d, flag_limit_q, flag_limit_d;
  logic [4:0] size;
  logic [5:0] mines;
  logic       clr_req;

  always_comb begin
    case (lvl_norm(level_q))
      2'd2:    begin size = 5'd10; mines = 6'(MINES_MEDIUM); end
      2'd3:    begin size = 5'd16; mines = 6'(MINES_HARD);   end
      default: begin size = 5'd8;  mines = 6'(MINES_EASY);   end
    endcase
  end

  // A level switch restarts the game exactly like an explicit new_game.
  assign clr_req = new_game | (lvl_norm(level) != lvl_norm(level_q));

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    lx_d         = lx_q;
    ly_d         = ly_q;
    ind_x_d      = ind_x_q;
    ind_y_d      = ind_y_q;
    flags_d      = flags_q;
    defuse_d     = 1'b0;
    undefuse_d   = 1'b0;
    flag_limit_d = 1'b0;
    if (clr_req) begin
      state_d = ST_CLEAR;
      cx_d    = 5'd0;
      cy_d    = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (click_req && (click_x < size) && (click_y < size)) begin
            lx_d    = click_x;
            ly_d    = click_y;
            state_d = ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_d = ST_DECIDE;
        ST_DECIDE: begin
          state_d = ST_IDLE;
          if (revealed_rd) begin
            flags_d = flags_q;
          end else if (flag_rd) begin
            undefuse_d = 1'b1;
            ind_x_d    = lx_q;
            ind_y_d    = ly_q;
            flags_d    = (flags_q >= mines) ? mines : flags_q + 6'd1;
          end else if (flags_q != 6'd0) begin
            defuse_d = 1'b1;
            ind_x_d  = lx_q;
            ind_y_d  = ly_q;
            flags_d  = flags_q - 6'd1;
          end else begin
            flag_limit_d = 1'b1;
          end
        end
        default: begin
          undefuse_d = 1'b1;
          ind_x_d    = cx_q;
          ind_y_d    = cy_q;
          if (cy_q >= size - 5'd1) begin
            cy_d = 5'd0;
            if (cx_q >= size - 5'd1) begin
              cx_d    = 5'd0;
              flags_d = mines;
              state_d = ST_IDLE;
            end else begin
              cx_d = cx_q + 5'd1;
            end
          end else begin
            cy_d = cy_q + 5'd1;
          end
        end
      endcase
    end
  end

  // Scan parks at (0,0) for the whole clear, so it restarts cleanly afterwards.
  always_comb begin
    rx_d = rx_q;
    ry_d = ry_q;
    if ((state_q == ST_CLEAR) || (state_d == ST_CLEAR) || (rx_q >= size) || (ry_q >= size)) begin
      rx_d = 5'd0;
      ry_d = 5'd0;
    end else if (ry_q == size - 5'd1) begin
      ry_d = 5'd0;
      rx_d = (rx_q == size - 5'd1) ? 5'd0 : rx_q + 5'd1;
    end else begin
      ry_d = ry_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= level;
      cx_q         <= 5'd0;
      cy_q         <= 5'd0;
      lx_q         <= 5'd0;
      ly_q         <= 5'd0;
      ind_x_q      <= 5'd0;
      ind_y_q      <= 5'd0;
      rx_q         <= 5'd0;
      ry_q         <= 5'd0;
      flags_q      <= 6'd0;
      defuse_q     <= 1'b0;
      undefuse_q   <= 1'b0;
      flag_limit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      ind_x_q      <= ind_x_d;
      ind_y_q      <= ind_y_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      flags_q      <= flags_d;
      defuse_q     <= defuse_d;
      undefuse_q   <= undefuse_d;
      flag_limit_q <= flag_limit_d;
    end
  end

  assign addr_x        = lx_q;
  assign addr_y        = ly_q;
  assign defuse        = defuse_q;
  assign undefuse      = undefuse_q;
  assign ind_x         = ind_x_q;
  assign ind_y         = ind_y_q;
  assign arr_x_refresh = rx_q;
  assign arr_y_refresh = ry_q;
  assign flags_left    = flags_q;
  assign flag_limit    = flag_limit_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/defuse_ctl.md
Name: defuse_ctl

Overview:
- Sequences right-click flag (defuse) requests and new-game clears for the defuse-field storage of the Saper board.
- Reads the addressed field's flag/revealed state, decides set, clear or reject, and issues single-cycle set/clear commands with a field index.
- Tracks remaining flags against the level's mine count.
- Generates the free-running refresh scan index (arr_x_refresh/arr_y_refresh) over the active board size.

Parameters:
- MINES_EASY, 10, mine count for level 1 (8x8).
- MINES_MEDIUM, 15, mine count for level 2 (10x10).
- MINES_HARD, 40, mine count for level 3 (16x16).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- level  in  2  1=easy (8), 2=medium (10), 3=hard (16); 0 treated as 1
- new_game  in  1  pulse; clear all flags and re-arm counter
- click_req  in  1  right-click request
- click_x  in  5  clicked field x index
- click_y  in  5  clicked field y index
- flag_rd  in  1  flag bit of field at addr_x/addr_y; valid one cycle after addr
- revealed_rd  in  1  revealed bit of field at addr_x/addr_y; same timing as flag_rd
- addr_x  out  5  lookup x index
- addr_y  out  5  lookup y index
- defuse  out  1  one-cycle set-flag command
- undefuse  out  1  one-cycle clear-flag command
- ind_x  out  5  command x index
- ind_y  out  5  command y index
- arr_x_refresh  out  5  refresh scan x
- arr_y_refresh  out  5  refresh scan y
- flags_left  out  6  remaining placeable flags
- flag_limit  out  1  one-cycle pulse: set rejected, no flags left
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: rst, synchronous, active-high; clock clk (all logic on posedge clk).
  - State = IDLE; every output = 0, including flags_left.
  - Counter is unarmed until the first new_game.
- size = 8/10/16 per level; mines = MINES_* per level.
- Registered level; a change of level is treated as new_game on the following cycle.
- States: IDLE, LOOKUP, DECIDE, CLEAR.
- IDLE:
  - click_req=1 with click_x<size and click_y<size: latch the coordinates, drive addr_x/addr_y, go to LOOKUP.
  - Out-of-range clicks are dropped silently.
  - click_req while not IDLE is ignored; there is no queue.
- LOOKUP: one wait cycle for the storage read. Go to DECIDE.
- DECIDE: sample flag_rd and revealed_rd, then return to IDLE. Exactly one of the following takes effect:
  - revealed_rd=1: no command.
  - flag_rd=1: undefuse=1 with ind=latched coordinates; flags_left+1, saturating at mines.
  - flag_rd=0 and flags_left>0: defuse=1; flags_left-1.
  - flag_rd=0 and flags_left=0: flag_limit=1; no command.
- Latency: click_req sampled at edge k → command or flag_limit asserted for exactly the cycle after edge k+2.
- CLEAR (entered on new_game from any state; new_game has priority over click):
  - Sweeps x=0..size-1 (outer), y=0..size-1 (inner), asserting undefuse with ind=(x,y) on each of size*size consecutive cycles.
  - On the last cell: flags_left := mines, go to IDLE.
  - new_game during CLEAR restarts the sweep at (0,0).
  - An in-flight click is abandoned.
- Refresh scan:
  - In IDLE/LOOKUP/DECIDE, y increments every cycle; at y=size-1, y wraps to 0 and x increments; at (size-1,size-1) it wraps to (0,0).
  - In CLEAR the scan is held at (0,0).
  - If a level change leaves the scan out of range, the next step wraps it to (0,0).
- defuse and undefuse are never high in the same cycle.
- ind_x/ind_y hold their last value when no command is issued.

Test Plan:
- rst mid-CLEAR → next cycle state IDLE, all outputs 0, undefuse low; new_game at level 1 then gives exactly 64 undefuse pulses, covering (0,0)..(7,7), then flags_left=10.
- Level 1 armed, click (3,5) with flag_rd=0, revealed_rd=0 → defuse high 3 cycles after click, ind=(3,5), flags_left 10→9, busy high for 2 cycles.
- Same cell re-clicked with flag_rd=1 → undefuse, ind=(3,5), flags_left 9→10; click with revealed_rd=1 → no pulse, flags_left unchanged.
- Level 3 armed, 40 sets, then 41st click on an unflagged cell → flag_limit pulse, no defuse, flags_left stays 0.
- Level 2: click (10,2) dropped (busy stays 0); click during LOOKUP ignored; new_game during DECIDE → no command, 100-cycle clear, flags_left=15.
- Level 2 idle: refresh scan goes (0,0)..(0,9),(1,0)…(9,9),(0,0), a 100-cycle period; switching level to 1 mid-scan triggers CLEAR, after which the scan restarts at (0,0) with period 64.
